cache_nway_wb: RTL
==================

// Module: cache_nway_wb
// PURPOSE
//  Parametrised N-way set-associative write-back, write-allocate cache. Replaces the direct-mapped
//  cache used for both the I and D sides of CHIP. Processor side is a word-addressed, stall-based port.
//  Memory side is the 128-bit slow_mem block port. Replacement is tree pseudo-LRU.
// PARAMETERS
//  WAYS      2   associativity; legal values 1, 2, 4
//  SETS      4   number of sets; power of two, 2..64; IDX_W = log2(SETS)
//  ADDR_W    30  processor word-address width; TAG_W = ADDR_W-2-IDX_W
// PORTS
//  clk         in   1    clock, rising edge
//  rst_n       in   1    asynchronous active-low reset
//  proc_read   in   1    word read request; held until proc_stall==0
//  proc_write  in   1    word write request; held until proc_stall==0
//  proc_addr   in   30   word address: [29:2+IDX_W] tag, [2+IDX_W-1:2] index, [1:0] word offset
//  proc_wdata  in   32   write data
//  proc_rdata  out  32   read data; valid in the cycle proc_stall==0 with proc_read==1
//  proc_stall  out  1    1 = request not yet complete
//  mem_read    out  1    block fill request
//  mem_write   out  1    block write-back request
//  mem_addr    out  28   block address (byte addr [31:4])
//  mem_wdata   out  128  write-back block; word0 in [31:0]
//  mem_rdata   in   128  fill block
//  mem_ready   in   1    one-cycle pulse: memory transaction done
//  hit_cnt     out  32   only with CACHE_PERF_CNT_EN
//  miss_cnt    out  32   only with CACHE_PERF_CNT_EN
// BEHAVIOUR
//  - Storage per set/way: valid, dirty, tag, 4x32 data. Per set: WAYS-1 PLRU bits.
//  - Reset (async, rst_n=0): all valid/dirty/PLRU bits = 0, FSM=IDLE, mem_read=mem_write=0,
//    mem_addr=0, mem_wdata=0, proc_rdata=0. Any in-flight memory transaction is abandoned.
//  - No request: proc_stall=0. proc_read&proc_write together is illegal; write takes priority.
//  - Hit (any way valid, tag equal): zero-wait. proc_stall=0 combinationally in the request cycle.
//    Read returns the word at offset. Write updates the word on the clock edge and sets dirty.
//    PLRU is updated to point away from the hit way.
//  - Miss: proc_stall=1 combinationally. Victim is the lowest-index invalid way, else the PLRU way.
//    The victim is latched on entry to WB/ALLOC and is not recomputed while the miss is serviced.
//  - FSM IDLE->WB  : miss, victim valid & dirty. mem_write=1, mem_addr={victim tag,index},
//                    mem_wdata=victim block, all registered and held stable until mem_ready.
//    FSM IDLE->ALLOC: miss, victim clean or invalid.
//    WB->ALLOC     : on mem_ready. mem_write drops on the next edge. Victim dirty is cleared.
//    ALLOC         : mem_read=1, mem_addr=proc_addr[29:2], held until mem_ready. Never both mem_read
//                    and mem_write in the same cycle.
//    ALLOC->IDLE   : on mem_ready. Block written to the victim way: valid=1, dirty=0, new tag.
//                    mem_read drops on the next edge.
//    IDLE (after refill): the request hits and completes one cycle after mem_ready, with proc_stall=0.
//  - Miss latency = 1 + memory cycles (+ write-back cycles). mem_ready outside WB/ALLOC is ignored.
//  - Write miss: allocate, then the write hit completes in IDLE and sets dirty.
//  - WAYS=1 degenerates to direct-mapped: no PLRU bits, victim = way 0.
//  - 4-way PLRU: bit0 selects the half (0 = ways 0/1); bit1/bit2 select within the half.
//    On an access, the bits on the path are set to point away from the accessed way.
// CONFIGURATION
//  CACHE_PERF_CNT_EN defined:
//    - hit_cnt increments once per hit-completed request cycle that was not a post-refill completion.
//    - miss_cnt increments once per IDLE->WB/ALLOC transition.
//    - Both are 32-bit, wrap at 2^32-1 -> 0, and reset to 0.
//  Not defined: hit_cnt/miss_cnt ports and counters do not exist; behaviour is otherwise identical.
// TESTING
//  1. Cold read 0x00000010 (SETS=4,WAYS=2): mem_read=1, mem_addr=0x0000004; mem_ready with
//     word0=0xDEADBEEF -> proc_rdata=0xDEADBEEF one cycle later, stall 0.
//  2. Write 0x12345678 to the same addr (hit) -> stall 0 in the same cycle; re-read returns 0x12345678,
//     no mem activity.
//  3. Fill both ways of set 0 (tags A, B), touch A, miss to tag C -> B is evicted, A is still a hit.
//  4. Dirty victim: write to A, force eviction -> mem_write=1 with A's block/addr first, then mem_read
//     for the new tag; never both high.
//  5. Assert rst_n=0 during ALLOC -> mem_read=0 immediately; after release, the same address misses again.
//  6. With CACHE_PERF_CNT_EN: 1 miss + 3 hits -> miss_cnt=1, hit_cnt=3.

Source files
------------

// File: rtl/cache_nway_wb.sv
// cache_nway_wb: N-way set-associative, write-back / write-allocate cache.
//   Processor side: word-addressed, stall-based request port (read/write held
//   until proc_stall drops). Hits complete with zero wait states.
//   Memory side: 128-bit block port; one transaction outstanding, finished by a
//   single-cycle mem_ready pulse.
//   Replacement: lowest invalid way first, otherwise tree pseudo-LRU.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   proc_read/proc_write       request strobes (write wins if both set)
//   proc_addr/proc_wdata       word address {tag,index,offset} and write data
//   proc_rdata/proc_stall      read data (valid when not stalled), stall
//   mem_read/mem_write         block fill / write-back request (registered)
//   mem_addr/mem_wdata         block address and write-back data (word0 in [31:0])
//   mem_rdata/mem_ready        fill data and completion pulse
//   hit_cnt/miss_cnt           performance counters, present only when the
//                              CACHE_PERF_CNT_EN macro is defined

module cache_way_cmp #(
  parameter int TAG_W = 24
) (
  input  logic             valid_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [TAG_W-1:0] ref_i,
  output logic             hit_o
);
  assign hit_o = valid_i && (tag_i == ref_i);
endmodule

module cache_nway_wb #(
  parameter int WAYS   = 2,
  parameter int SETS   = 4,
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [31:0]       proc_wdata,
  output logic [31:0]       proc_rdata,
  output logic              proc_stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic [127:0]      mem_rdata,
  input  logic              mem_ready
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - 2 - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_ALLOC} state_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
  } req_t;

  // storage
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [PLRU_W-1:0] plru_q  [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [3:0][31:0]  data_q  [SETS][WAYS];

  state_e            state_q, state_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [127:0]      mem_wdata_q, mem_wdata_d;

  req_t              rq;
  logic              req, hit, hit_en, vic_found;
  logic [WAYS-1:0]   hit_vec;
  logic [WAY_W-1:0]  hit_way, vic_way;
  logic              miss_start, wb_done, fill_done;
  logic [IDX_W-1:0]  fidx;
  logic [TAG_W-1:0]  ftag;

  assign rq  = req_t'(proc_addr);
  assign req = proc_read | proc_write;

  // PLRU bit value names the way to evict next (tree form for 4 ways).
  function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] b);
    logic [2:0]       pb;
    logic [WAY_W-1:0] v;
    pb = 3'(b);
    v  = '0;
    if (WAYS == 2)      v = WAY_W'(pb[0]);
    else if (WAYS == 4) v = pb[0] ? WAY_W'({1'b1, pb[2]}) : WAY_W'({1'b0, pb[1]});
    return v;
  endfunction

  // Point every bit on the accessed way's path away from it.
  function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] b,
                                                   input logic [WAY_W-1:0]  w);
    logic [2:0] pb;
    logic [1:0] ww;
    pb = 3'(b);
    ww = 2'(w);
    if (WAYS == 2) pb[0] = ~ww[0];
    else if (WAYS == 4) begin
      pb[0] = ~ww[1];
      if (ww[1]) pb[2] = ~ww[0];
      else       pb[1] = ~ww[0];
    end
    return PLRU_W'(pb);
  endfunction

  // per-way tag compare
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way_cmp #(.TAG_W(TAG_W)) u_cmp (
      .valid_i (valid_q[rq.idx][w]),
      .tag_i   (tag_q[rq.idx][w]),
      .ref_i   (rq.tag),
      .hit_o   (hit_vec[w])
    );
  end

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (hit_vec[w]) hit_way = WAY_W'(w);
  end

  always_comb begin
    vic_way   = plru_victim(plru_q[rq.idx]);
    vic_found = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (!vic_found && !valid_q[rq.idx][w]) begin
        vic_way   = WAY_W'(w);
        vic_found = 1'b1;
      end
  end

  assign hit        = |hit_vec;
  assign hit_en     = (state_q == S_IDLE) && req && hit;
  assign proc_stall = (state_q != S_IDLE) || (req && !hit);
  assign proc_rdata = (hit_en && proc_read) ? data_q[rq.idx][hit_way][rq.off] : 32'h0;

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // During WB and ALLOC mem_addr_q carries the set index of the line being
  // serviced, so the refill does not depend on proc_addr staying stable.
  assign fidx = mem_addr_q[IDX_W-1:0];
  assign ftag = mem_addr_q[ADDR_W-3:IDX_W];

  always_comb begin
    state_d     = state_q;
    victim_d    = victim_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    miss_start  = 1'b0;
    wb_done     = 1'b0;
    fill_done   = 1'b0;
    case (state_q)
      S_IDLE: if (req && !hit) begin
        miss_start = 1'b1;
        victim_d   = vic_way;
        if (valid_q[rq.idx][vic_way] && dirty_q[rq.idx][vic_way]) begin
          state_d     = S_WB;
          mem_write_d = 1'b1;
          mem_addr_d  = {tag_q[rq.idx][vic_way], rq.idx};
          mem_wdata_d = data_q[rq.idx][vic_way];
        end else begin
          state_d    = S_ALLOC;
          mem_read_d = 1'b1;
          mem_addr_d = proc_addr[ADDR_W-1:2];
        end
      end
      S_WB: if (mem_ready) begin
        wb_done     = 1'b1;
        state_d     = S_ALLOC;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b1;
        mem_addr_d  = proc_addr[ADDR_W-1:2];
      end
      S_ALLOC: if (mem_ready) begin
        fill_done  = 1'b1;
        state_d    = S_IDLE;
        mem_read_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      victim_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      victim_q    <= victim_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // line state: valid / dirty / PLRU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (hit_en) begin
        plru_q[rq.idx] <= plru_touch(plru_q[rq.idx], hit_way);
        if (proc_write) dirty_q[rq.idx][hit_way] <= 1'b1;
      end
      if (wb_done) dirty_q[fidx][victim_q] <= 1'b0;
      if (fill_done) begin
        valid_q[fidx][victim_q] <= 1'b1;
        dirty_q[fidx][victim_q] <= 1'b0;
      end
    end
  end

  // tag / data arrays carry no reset; valid bits gate their use
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[fidx][victim_q]  <= ftag;
      data_q[fidx][victim_q] <= mem_rdata;
    end
    if (hit_en && proc_write) data_q[rq.idx][hit_way][rq.off] <= proc_wdata;
  end

`ifdef CACHE_PERF_CNT_EN
  // The completion right after a refill belongs to the miss, not to hits.
  logic        post_refill_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_refill_q <= 1'b0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      post_refill_q <= fill_done;
      if (hit_en && !post_refill_q) hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start)               miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
